// File: rtl/dmem_subword.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_subword : byte-addressed data memory, byte/half/word/dword access,     |
// | sign/zero-extended registered loads, zero-fill after reset.                 |
// | Optional: `define DMEM_PARITY_EN for per-byte even parity + Parity_Err.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module dmem_subword #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  Mem_Write,
  input  logic                  Mem_Read,
  input  logic [1:0]            Mem_Size,
  input  logic                  Mem_Unsigned,
  output logic [DATA_WIDTH-1:0] Read_Data,
  output logic                  Read_Valid,
  output logic                  Access_Err,
`ifdef DMEM_PARITY_EN
  output logic                  Parity_Err,
`endif
  output logic                  Busy
);

  localparam int c_NBYTES = DATA_WIDTH / 8;
  localparam int c_OFF_W  = $clog2(c_NBYTES);
  localparam int c_IDX_W  = ADDR_WIDTH - c_OFF_W;
  localparam int c_DEPTH  = 1 << c_IDX_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_IDX_W-1:0]    r_cnt;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_valid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  logic [c_OFF_W-1:0]    w_off;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_size_ok;
  logic                  w_aligned;
  logic                  w_err;
  logic                  w_idle;
  logic                  w_do_write;
  logic                  w_do_read;
  logic [c_NBYTES-1:0]   w_lenmask;
  logic [c_NBYTES-1:0]   w_be;
  logic [DATA_WIDTH-1:0] w_wdata_sh;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_fmask;
  logic                  w_msb;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_off      = Address[c_OFF_W-1:0];
  assign w_idx      = Address[ADDR_WIDTH-1:c_OFF_W];
  assign w_idle     = (r_state == ST_IDLE);
  assign w_err      = !(w_size_ok && w_aligned);
  assign w_do_write = w_idle && Mem_Write && !w_err;
  assign w_do_read  = w_idle && Mem_Read && !Mem_Write && !w_err;
  assign w_be       = w_lenmask << w_off;
  assign w_wdata_sh = Write_Data << {w_off, 3'b000};
  assign w_word     = r_mem[w_idx];
  assign w_shift    = w_word >> {w_off, 3'b000};

  always_comb begin
    w_size_ok = 1'b1;
    w_aligned = 1'b1;
    w_lenmask = '1;
    w_fmask   = '1;
    w_msb     = w_shift[DATA_WIDTH-1];
    case (Mem_Size)
      2'b00: begin
        w_lenmask = c_NBYTES'(1);
        w_fmask   = DATA_WIDTH'(8'hFF);
        w_msb     = w_shift[7];
      end
      2'b01: begin
        w_aligned = (Address[0] == 1'b0);
        w_lenmask = c_NBYTES'(3);
        w_fmask   = DATA_WIDTH'(16'hFFFF);
        w_msb     = w_shift[15];
      end
      2'b10: begin
        w_aligned = (Address[1:0] == 2'b00);
        w_lenmask = c_NBYTES'(15);
        w_fmask   = DATA_WIDTH'(32'hFFFF_FFFF);
        w_msb     = w_shift[31];
      end
      default: begin
        // Doubleword exists only in 64-bit builds.
        w_size_ok = (DATA_WIDTH == 64);
        w_aligned = (Address[2:0] == 3'b000);
      end
    endcase
    w_load = (w_shift & w_fmask) | (~w_fmask & {DATA_WIDTH{w_msb & ~Mem_Unsigned}});
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_do_write) begin
      for (int b = 0; b < c_NBYTES; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [c_NBYTES-1:0] r_par [c_DEPTH];
  logic [c_NBYTES-1:0] w_par_calc;
  logic [c_NBYTES-1:0] w_par_wr;
  logic                w_par_bad;
  logic                r_par_err;

  always_comb begin
    w_par_calc = '0;
    w_par_wr   = '0;
    for (int b = 0; b < c_NBYTES; b++) begin
      w_par_calc[b] = ^w_word[8*b +: 8];
      w_par_wr[b]   = ^w_wdata_sh[8*b +: 8];
    end
  end
  assign w_par_bad = |(w_be & (r_par[w_idx] ^ w_par_calc));

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_par[r_cnt] <= '0;
    end else if (w_do_write) begin
      for (int b = 0; b < c_NBYTES; b++) begin
        if (w_be[b]) r_par[w_idx][b] <= w_par_wr[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par_err <= 1'b0;
    else        r_par_err <= w_do_read && w_par_bad;
  end
  assign Parity_Err = r_par_err;

  task automatic corrupt_parity(input logic [c_IDX_W-1:0] idx, input int lane);
    r_par[idx][lane] = ~r_par[idx][lane];
  endtask
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
      r_busy  <= (INIT_ZERO != 0);
      r_cnt   <= '0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + c_IDX_W'(1);
          if (r_cnt == c_IDX_W'(c_DEPTH - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          if ((Mem_Read || Mem_Write) && w_err) begin
            r_err <= 1'b1;
            if (Mem_Read && !Mem_Write) begin
              r_valid <= 1'b1;
              r_rdata <= '0;
            end
          end else if (w_do_read) begin
            r_valid <= 1'b1;
            r_rdata <= w_load;
          end
        end
      endcase
    end
  end

  assign Read_Data  = r_rdata;
  assign Read_Valid = r_valid;
  assign Access_Err = r_err;
  assign Busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dmem_subword.sv
`default_nettype none
// Directed self-checking bench for dmem_subword (32-bit data, 8-bit address).
module tb_dmem_subword;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  Address = '0;
  logic [31:0] Write_Data = '0;
  logic        Mem_Write = 1'b0;
  logic        Mem_Read = 1'b0;
  logic [1:0]  Mem_Size = 2'b10;
  logic        Mem_Unsigned = 1'b0;
  logic [31:0] Read_Data;
  logic        Read_Valid;
  logic        Access_Err;
  logic        Busy;
`ifdef DMEM_PARITY_EN
  logic        Parity_Err;
`endif

  int n_pass  = 0;
  int n_total = 0;

  dmem_subword #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .Write_Data(Write_Data),
    .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .Mem_Size(Mem_Size),
    .Mem_Unsigned(Mem_Unsigned), .Read_Data(Read_Data), .Read_Valid(Read_Valid),
    .Access_Err(Access_Err),
`ifdef DMEM_PARITY_EN
    .Parity_Err(Parity_Err),
`endif
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Mem_Write = 1'b0;
    Mem_Read  = 1'b0;
  endtask

  task automatic store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
    Address = a; Mem_Size = sz; Write_Data = d; Mem_Write = 1'b1; Mem_Read = 1'b0;
    cycle();
    idle_inputs();
  endtask

  task automatic load(input logic [7:0] a, input logic [1:0] sz, input logic uns);
    Address = a; Mem_Size = sz; Mem_Unsigned = uns; Mem_Read = 1'b1; Mem_Write = 1'b0;
    cycle();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++; if (Read_Data !== 32'h0) $display("FAIL reset_data: got %h expected %h", Read_Data, 32'h0); else n_pass++;
    n_total++; if (Read_Valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", Read_Valid); else n_pass++;
    n_total++; if (Access_Err !== 1'b0) $display("FAIL reset_err: got %b expected 0", Access_Err); else n_pass++;
    n_total++; if (Busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", Busy); else n_pass++;
  endtask

  task automatic test_init_busy();
    int  n;
    logic saw_valid;
    n = 0;
    saw_valid = 1'b0;
    @(posedge clk); #1;
    Address = 8'h10; Mem_Size = 2'b10; Mem_Read = 1'b1;
    rst_n = 1'b1;
    while (Busy === 1'b1 && n < 200) begin
      cycle();
      n++;
      if (Read_Valid !== 1'b0 || Access_Err !== 1'b0) saw_valid = 1'b1;
    end
    idle_inputs();
    n_total++; if (saw_valid !== 1'b0) $display("FAIL init_no_valid: got %b expected 0", saw_valid); else n_pass++;
    n_total++; if (n != 64) $display("FAIL init_len: got %0d expected 64", n); else n_pass++;
    load(8'h10, 2'b10, 1'b0);
    n_total++; if (Read_Valid !== 1'b1) $display("FAIL init_read_valid: got %b expected 1", Read_Valid); else n_pass++;
    n_total++; if (Read_Data !== 32'h0) $display("FAIL init_read_zero: got %h expected %h", Read_Data, 32'h0); else n_pass++;
  endtask

  task automatic test_word();
    store(8'h10, 2'b10, 32'hA5A5A5A5);
    n_total++; if (Read_Valid !== 1'b0) $display("FAIL store_no_valid: got %b expected 0", Read_Valid); else n_pass++;
    load(8'h10, 2'b10, 1'b0);
    n_total++; if (Read_Valid !== 1'b1) $display("FAIL word_valid: got %b expected 1", Read_Valid); else n_pass++;
    n_total++; if (Read_Data !== 32'hA5A5A5A5) $display("FAIL word_data: got %h expected %h", Read_Data, 32'hA5A5A5A5); else n_pass++;
  endtask

  task automatic test_subword();
    store(8'h12, 2'b00, 32'h00000080);
    load(8'h12, 2'b00, 1'b0);
    n_total++; if (Read_Data !== 32'hFFFFFF80) $display("FAIL byte_signed: got %h expected %h", Read_Data, 32'hFFFFFF80); else n_pass++;
    load(8'h12, 2'b00, 1'b1);
    n_total++; if (Read_Data !== 32'h00000080) $display("FAIL byte_unsigned: got %h expected %h", Read_Data, 32'h00000080); else n_pass++;
    load(8'h10, 2'b10, 1'b0);
    n_total++; if (Read_Data !== 32'hA580A5A5) $display("FAIL byte_merge: got %h expected %h", Read_Data, 32'hA580A5A5); else n_pass++;
    load(8'h12, 2'b01, 1'b0);
    n_total++; if (Read_Data !== 32'hFFFFA580) $display("FAIL half_signed: got %h expected %h", Read_Data, 32'hFFFFA580); else n_pass++;
    load(8'h10, 2'b01, 1'b1);
    n_total++; if (Read_Data !== 32'h0000A5A5) $display("FAIL half_unsigned: got %h expected %h", Read_Data, 32'h0000A5A5); else n_pass++;
  endtask

  task automatic test_errors();
    load(8'h11, 2'b01, 1'b0);
    n_total++; if (Access_Err !== 1'b1) $display("FAIL mis_half_err: got %b expected 1", Access_Err); else n_pass++;
    n_total++; if (Read_Valid !== 1'b1) $display("FAIL mis_half_valid: got %b expected 1", Read_Valid); else n_pass++;
    n_total++; if (Read_Data !== 32'h0) $display("FAIL mis_half_data: got %h expected %h", Read_Data, 32'h0); else n_pass++;
    cycle();
    n_total++; if (Access_Err !== 1'b0) $display("FAIL err_pulse: got %b expected 0", Access_Err); else n_pass++;
    store(8'h12, 2'b10, 32'hFFFFFFFF);
    n_total++; if (Access_Err !== 1'b1) $display("FAIL mis_word_err: got %b expected 1", Access_Err); else n_pass++;
    n_total++; if (Read_Valid !== 1'b0) $display("FAIL mis_word_valid: got %b expected 0", Read_Valid); else n_pass++;
    load(8'h10, 2'b11, 1'b0);
    n_total++; if (Access_Err !== 1'b1) $display("FAIL dword_illegal: got %b expected 1", Access_Err); else n_pass++;
    load(8'h10, 2'b10, 1'b0);
    n_total++; if (Read_Data !== 32'hA580A5A5) $display("FAIL err_no_write: got %h expected %h", Read_Data, 32'hA580A5A5); else n_pass++;
  endtask

  task automatic test_rw_both();
    Address = 8'h14; Mem_Size = 2'b10; Write_Data = 32'h5A5A5A5A;
    Mem_Write = 1'b1; Mem_Read = 1'b1;
    cycle();
    idle_inputs();
    n_total++; if (Read_Valid !== 1'b0) $display("FAIL rw_no_valid: got %b expected 0", Read_Valid); else n_pass++;
    load(8'h14, 2'b10, 1'b0);
    n_total++; if (Read_Data !== 32'h5A5A5A5A) $display("FAIL rw_write: got %h expected %h", Read_Data, 32'h5A5A5A5A); else n_pass++;
  endtask

  task automatic test_back_to_back();
    store(8'h18, 2'b10, 32'h11223344);
    load(8'h18, 2'b10, 1'b0);
    n_total++; if (Read_Data !== 32'h11223344) $display("FAIL st_ld: got %h expected %h", Read_Data, 32'h11223344); else n_pass++;
    Address = 8'h18; Mem_Size = 2'b00; Mem_Unsigned = 1'b1; Mem_Read = 1'b1;
    cycle();
    n_total++; if (Read_Valid !== 1'b1 || Read_Data !== 32'h44) $display("FAIL b2b_0: got %b/%h expected 1/%h", Read_Valid, Read_Data, 32'h44); else n_pass++;
    Address = 8'h19;
    cycle();
    idle_inputs();
    n_total++; if (Read_Valid !== 1'b1 || Read_Data !== 32'h33) $display("FAIL b2b_1: got %b/%h expected 1/%h", Read_Valid, Read_Data, 32'h33); else n_pass++;
    cycle();
    n_total++; if (Read_Valid !== 1'b0 || Read_Data !== 32'h33) $display("FAIL hold: got %b/%h expected 0/%h", Read_Valid, Read_Data, 32'h33); else n_pass++;
  endtask

  task automatic test_reset_mid_init();
    int n;
    n = 0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (20) cycle();
    rst_n = 1'b0;
    cycle();
    n_total++; if (Busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", Busy); else n_pass++;
    rst_n = 1'b1;
    while (Busy === 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    n_total++; if (n != 64) $display("FAIL mid_len: got %0d expected 64", n); else n_pass++;
    load(8'h10, 2'b10, 1'b0);
    n_total++; if (Read_Data !== 32'h0) $display("FAIL mid_zeroed: got %h expected %h", Read_Data, 32'h0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init_busy();
    test_word();
    test_subword();
    test_errors();
    test_rw_both();
    test_back_to_back();
    test_reset_mid_init();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
